bcd_updown_counter: RTL

Parametrised synchronous successor to the 4-bit ripple T-flip-flop counter. Counts DIGITS decimal (BCD) digits up or down, one step per rising edge of a debounced button level. It supports synchronous load, a wrap or saturate limit mode, and a one-cycle wrap pulse for cascading. It sits between the debounce block and the per-digit BCD7 decoders; every flop is clocked by the system clk, and no derived clocks are used.

---
 rtl/bcd_updown_counter.sv | 110 +++++++++++
 1 files changed

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter
//   Synchronous multi-digit BCD up/down counter, one count per rising edge of a
//   debounced button level. Supports a synchronous load with per-digit clamping,
//   wrap or saturate behaviour at the limits, and a one-cycle wrap pulse for
//   cascading.
//
// Parameters
//   DIGITS     number of BCD digits (1..8); count width is 4*DIGITS
//   SATURATE   0 = wrap at the limits, 1 = hold at all-9s (up) / all-0s (down)
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high; clears all state
//   step        debounced button level; a 0->1 transition requests one count
//   up          direction: 1 = increment, 0 = decrement
//   load        synchronous load strobe (level, active-high), beats step
//   load_value  BCD value to load, digit i at [4i+3:4i]; digits >9 clamp to 9
//   count       current BCD count, digit 0 least significant
//   wrap        registered one-cycle pulse on all-9s->0 (up) or 0->all-9s (down)
//   at_limit    combinational: count at all-9s with up=1, or at 0 with up=0
module bcd_updown_counter #(
  parameter int unsigned DIGITS   = 2,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic                  at_limit
);

  localparam int unsigned   W         = 4 * DIGITS;
  localparam logic [W-1:0]  ALL_NINES = {DIGITS{4'h9}};

  logic         step_q;
  logic         armed;
  logic         step_edge;
  logic [W-1:0] count_next;
  logic         wrap_next;
  logic         carry;
  logic [3:0]   dig;

  assign at_limit = up ? (count == ALL_NINES) : (count == '0);

  // armed stays low for the first clk after reset so that a step level already
  // high at release only primes step_q instead of being seen as an edge.
  assign step_edge = armed & step & ~step_q;

  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    carry      = 1'b1;
    dig        = '0;
    if (load) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        dig = load_value[4*i +: 4];
        count_next[4*i +: 4] = (dig > 4'd9) ? 4'd9 : dig;
      end
    end else if (step_edge) begin
      if (at_limit) begin
        if (!SATURATE) begin
          count_next = up ? '0 : ALL_NINES;
          wrap_next  = 1'b1;
        end
      end else begin
        // Ripple carry/borrow: each digit moves only while the lower digits
        // all rolled over.
        for (int unsigned i = 0; i < DIGITS; i++) begin
          dig = count[4*i +: 4];
          if (carry) begin
            if (up) begin
              if (dig == 4'd9) begin
                count_next[4*i +: 4] = 4'd0;
              end else begin
                count_next[4*i +: 4] = dig + 4'd1;
                carry = 1'b0;
              end
            end else begin
              if (dig == 4'd0) begin
                count_next[4*i +: 4] = 4'd9;
              end else begin
                count_next[4*i +: 4] = dig - 4'd1;
                carry = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      wrap   <= 1'b0;
      step_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      step_q <= step;
      armed  <= 1'b1;
      count  <= count_next;
      wrap   <= wrap_next;
    end
  end

endmodule
